// File: rtl/line_w_load_pkg.sv
// line_w_load_pkg: opcode/funct constants, load-type enum and load-type decode
package line_w_load_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_LB = 6'h20;
  localparam logic [5:0] OP_LH = 6'h21;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] FN_JR = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [4:0] GRF_RA = 5'd31;
  typedef enum logic [2:0] {LD_NONE, LD_B, LD_BU, LD_H, LD_HU, LD_W} ld_t;
  function automatic ld_t ld_type(input logic [5:0] op);
    return op == OP_LB  ? LD_B  :
           op == OP_LBU ? LD_BU :
           op == OP_LH  ? LD_H  :
           op == OP_LHU ? LD_HU :
           op == OP_LW  ? LD_W  : LD_NONE;
  endfunction
endpackage

// File: rtl/line_w_load_load_ext.sv
// load_ext: picks the addressed byte/half/word lane, extends it and flags misalignment
module load_ext
  import line_w_load_pkg::*;
(
  input  logic [1:0]  a,
  input  ld_t         ty,
  input  logic [31:0] word,
  output logic [31:0] data,
  output logic        misaligned
);
  logic [7:0] b;
  logic [15:0] h;
  assign b = word[{a, 3'b000} +: 8];
  assign h = a[1] ? word[31:16] : word[15:0];
  assign data = ty == LD_B  ? {{24{b[7]}}, b}  :
                ty == LD_BU ? {24'd0, b}        :
                ty == LD_H  ? {{16{h[15]}}, h} :
                ty == LD_HU ? {16'd0, h}        : word;
  assign misaligned = (ty == LD_W && a != 2'd0) || ((ty == LD_H || ty == LD_HU) && a[0]);
endmodule

// File: rtl/line_w_load.sv
// line_w_load: W stage - pipeline register, load extraction, GRF write select, retire counter
module line_w_load
  import line_w_load_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ins_in,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      alu_result_in,
  input  logic [31:0]      dm_data_in,
  output logic [31:0]      ins_w,
  output logic [31:0]      pc_w,
  output logic             grf_we,
  output logic [4:0]       grf_addr,
  output logic [31:0]      grf_wdata,
  output logic             load_misaligned,
  output logic [CNT_W-1:0] retired
);
  logic [31:0] alu_w, dm_w, ld_data, link;
  logic [5:0] op, fn;
  ld_t ld;
  assign op = ins_w[31:26];
  assign fn = ins_w[5:0];
  assign ld = ld_type(op);
  assign link = pc_w + 32'd8;
  load_ext u_load_ext (
    .a          (alu_w[1:0]),
    .ty         (ld),
    .word       (dm_w),
    .data       (ld_data),
    .misaligned (load_misaligned)
  );
  // Capture M results every cycle; count the instruction that leaves W unless it is a nop
  always_ff @(posedge clk) begin
    if (reset) begin
      ins_w <= 32'd0;
      pc_w <= PC_RESET;
      alu_w <= 32'd0;
      dm_w <= 32'd0;
      retired <= '0;
    end else begin
      ins_w <= ins_in;
      pc_w <= pc_in;
      alu_w <= alu_result_in;
      dm_w <= dm_data_in;
      retired <= retired + {{(CNT_W-1){1'b0}}, |ins_w};
    end
  end
  // Destination register and write data from the instruction class in W
  always_comb begin
    grf_addr = 5'd0;
    grf_wdata = alu_w;
    if (op == OP_RTYPE && fn != FN_JR && ins_w != 32'd0) begin
      grf_addr = ins_w[15:11];
      grf_wdata = fn == FN_JALR ? link : alu_w;
    end else if (op[5:3] == 3'b001) begin
      grf_addr = ins_w[20:16];
    end else if (op == OP_JAL) begin
      grf_addr = GRF_RA;
      grf_wdata = link;
    end else if (ld != LD_NONE) begin
      grf_addr = ins_w[20:16];
      grf_wdata = ld_data;
    end
  end
  assign grf_we = grf_addr != 5'd0 && !load_misaligned;
endmodule

// File: tb/tb_line_w_load.sv
// tb_line_w_load: vector table, directed corner sequences and random checks against a reference model
module tb_line_w_load;
  logic clk = 0, reset = 1;
  logic [31:0] ins_in = 0, pc_in = 0, alu_result_in = 0, dm_data_in = 0;
  logic [31:0] ins_w, pc_w, grf_wdata;
  logic grf_we, load_misaligned;
  logic [4:0] grf_addr;
  logic [31:0] retired;
  int errs = 0, checks = 0;
  logic [31:0] exp_ret = 0, last_ins = 0;

  line_w_load dut (
    .clk(clk), .reset(reset), .ins_in(ins_in), .pc_in(pc_in),
    .alu_result_in(alu_result_in), .dm_data_in(dm_data_in),
    .ins_w(ins_w), .pc_w(pc_w), .grf_we(grf_we), .grf_addr(grf_addr),
    .grf_wdata(grf_wdata), .load_misaligned(load_misaligned), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins, pc, alu, dm;
    logic we;
    logic [4:0] addr;
    logic [31:0] wdata;
    logic mis;
  } vec_t;

  typedef struct {
    logic we;
    logic [4:0] addr;
    logic [31:0] wdata;
    logic mis;
  } res_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a, input logic [31:0] d);
    ins_in = i;
    pc_in = p;
    alu_result_in = a;
    dm_data_in = d;
    if (reset) begin
      exp_ret = 0;
      last_ins = 0;
    end else begin
      if (last_ins != 0) exp_ret++;
      last_ins = i;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic res_t model(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] dm);
    res_t r;
    int op, fn, a;
    logic [31:0] v;
    op = int'(ins[31:26]);
    fn = int'(ins[5:0]);
    a = int'(alu % 4);
    r.addr = 0;
    r.wdata = 0;
    r.mis = 0;
    if (op == 0 && ins != 0 && fn != 8) begin
      r.addr = ins[15:11];
      r.wdata = fn == 9 ? pc + 8 : alu;
    end else if (op >= 8 && op <= 15) begin
      r.addr = ins[20:16];
      r.wdata = alu;
    end else if (op == 3) begin
      r.addr = 31;
      r.wdata = pc + 8;
    end else if (op == 'h20 || op == 'h24) begin
      r.addr = ins[20:16];
      v = (dm >> (8 * a)) & 32'hFF;
      r.wdata = (op == 'h20 && v >= 128) ? v - 256 : v;
    end else if (op == 'h21 || op == 'h25) begin
      r.addr = ins[20:16];
      v = (dm >> (16 * (a / 2))) & 32'hFFFF;
      r.wdata = (op == 'h21 && v >= 32768) ? v - 65536 : v;
      r.mis = a % 2 == 1;
    end else if (op == 'h23) begin
      r.addr = ins[20:16];
      r.wdata = dm;
      r.mis = a != 0;
    end
    r.we = r.addr != 0 && !r.mis;
    return r;
  endfunction

  vec_t tbl[13];
  res_t r;
  logic [31:0] ri, rp, ra, rd;
  int k;

  initial begin
    tbl[0]  = '{{6'h20, 5'd0, 5'd8, 16'd3}, 32'h3000, 32'h3, 32'h80FF_1234, 1, 8, 32'hFFFF_FF80, 0};
    tbl[1]  = '{{6'h24, 5'd0, 5'd8, 16'd3}, 32'h3004, 32'h3, 32'h80FF_1234, 1, 8, 32'h0000_0080, 0};
    tbl[2]  = '{{6'h21, 5'd0, 5'd9, 16'd2}, 32'h3008, 32'h2, 32'h8001_7FFF, 1, 9, 32'hFFFF_8001, 0};
    tbl[3]  = '{{6'h25, 5'd0, 5'd9, 16'd2}, 32'h300C, 32'h2, 32'h8001_7FFF, 1, 9, 32'h0000_8001, 0};
    tbl[4]  = '{{6'h23, 5'd0, 5'd7, 16'd5}, 32'h3010, 32'h5, 32'h1234_5678, 0, 7, 32'h1234_5678, 1};
    tbl[5]  = '{{6'h21, 5'd0, 5'd6, 16'd1}, 32'h3014, 32'h1, 32'h1234_5678, 0, 6, 32'h0000_5678, 1};
    tbl[6]  = '{{6'h03, 26'h0000C04}, 32'h3010, 32'h0, 32'h0, 1, 31, 32'h0000_3018, 0};
    tbl[7]  = '{{6'h00, 5'd1, 5'd0, 5'd4, 5'd0, 6'h09}, 32'h3020, 32'h55, 32'h0, 1, 4, 32'h0000_3028, 0};
    tbl[8]  = '{{6'h00, 5'd31, 15'd0, 6'h08}, 32'h3024, 32'h0, 32'h0, 0, 0, 32'h0, 0};
    tbl[9]  = '{{6'h2B, 5'd1, 5'd2, 16'd4}, 32'h3028, 32'h4, 32'h0, 0, 0, 32'h4, 0};
    tbl[10] = '{{6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h21}, 32'h302C, 32'h77, 32'h0, 0, 0, 32'h77, 0};
    tbl[11] = '{{6'h09, 5'd0, 5'd5, 16'd7}, 32'h3030, 32'h7, 32'h0, 1, 5, 32'h7, 0};
    tbl[12] = '{{6'h03, 26'h0}, 32'hFFFF_FFFC, 32'h0, 32'h0, 1, 31, 32'h4, 0};

    reset = 1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rst_pc", pc_w, 32'h3000);
    chk("rst_ins", ins_w, 0);
    chk("rst_we", {31'd0, grf_we}, 0);
    chk("rst_addr", {27'd0, grf_addr}, 0);
    chk("rst_wdata", grf_wdata, 0);
    chk("rst_mis", {31'd0, load_misaligned}, 0);
    chk("rst_ret", retired, 0);
    reset = 0;
    step(0, 32'h3000, 0, 0);
    chk("rel_pc", pc_w, 32'h3000);
    chk("rel_we", {31'd0, grf_we}, 0);
    chk("rel_ret", retired, 0);

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].ins, tbl[i].pc, tbl[i].alu, tbl[i].dm);
      chk($sformatf("v%0d_we", i), {31'd0, grf_we}, {31'd0, tbl[i].we});
      chk($sformatf("v%0d_mis", i), {31'd0, load_misaligned}, {31'd0, tbl[i].mis});
      if (tbl[i].we) begin
        chk($sformatf("v%0d_addr", i), {27'd0, grf_addr}, {27'd0, tbl[i].addr});
        chk($sformatf("v%0d_wdata", i), grf_wdata, tbl[i].wdata);
      end
      chk($sformatf("v%0d_ret", i), retired, exp_ret);
    end

    for (int i = 0; i < 400; i++) begin
      k = int'($urandom_range(0, 9));
      ri = $urandom;
      case (k)
        0: ri[31:26] = 6'h00;
        1: ri[31:26] = 6'(8 + $urandom_range(0, 7));
        2: ri[31:26] = 6'h03;
        3: ri[31:26] = 6'h20;
        4: ri[31:26] = 6'h21;
        5: ri[31:26] = 6'h23;
        6: ri[31:26] = 6'h24;
        7: ri[31:26] = 6'h25;
        8: ri[31:26] = 6'h2B;
        default: ri = 0;
      endcase
      if (k == 0 && $urandom_range(0, 2) == 0) ri[5:0] = $urandom_range(0, 1) ? 6'h08 : 6'h09;
      rp = $urandom;
      ra = $urandom;
      rd = $urandom;
      step(ri, rp, ra, rd);
      r = model(ri, rp, ra, rd);
      chk("rnd_we", {31'd0, grf_we}, {31'd0, r.we});
      chk("rnd_mis", {31'd0, load_misaligned}, {31'd0, r.mis});
      if (r.we) begin
        chk("rnd_addr", {27'd0, grf_addr}, {27'd0, r.addr});
        chk("rnd_wdata", grf_wdata, r.wdata);
      end
      chk("rnd_ret", retired, exp_ret);
    end

    reset = 1;
    step(0, 0, 0, 0);
    reset = 0;
    for (int i = 0; i < 5; i++) step({6'h09, 5'd0, 5'd3, 16'd1}, 32'h3000 + 4 * i, 32'd1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("seq_ret5", retired, 5);
    chk("seq_ret_model", retired, exp_ret);
    reset = 1;
    step({6'h23, 5'd0, 5'd10, 16'd0}, 32'h3040, 32'h0, 32'hDEAD_BEEF);
    chk("seq_ret0", retired, 0);
    chk("seq_we_after_rst", {31'd0, grf_we}, 0);
    chk("seq_ins_after_rst", ins_w, 0);
    reset = 0;
    step({6'h23, 5'd0, 5'd10, 16'd0}, 32'h3044, 32'h0, 32'hDEAD_BEEF);
    chk("seq_lw_addr", {27'd0, grf_addr}, 10);
    chk("seq_lw_wdata", grf_wdata, 32'hDEAD_BEEF);
    chk("seq_ret_still0", retired, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
